// File: rtl/fifo_drain_pkg.sv
// Shared defaults and FSM state type for the fifo_drain read controller.
package fifo_drain_pkg;

   localparam int DEF_DW        = 8;
   localparam int DEF_AW        = 4;
   localparam int DEF_BURST_LEN = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

endpackage

// File: rtl/fifo_drain_skid.sv
// Two-entry in-order output buffer: tail write, head pop, registered head data.
module fifo_drain_skid
   import fifo_drain_pkg::*;
#(
   parameter int DW = DEF_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_wr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_pop,
   output logic [DW-1:0] o_head,
   output logic [1:0]    o_occ
);

   logic [DW-1:0] r_mem0;
   logic [DW-1:0] r_mem1;
   logic [1:0]    r_occ;

   // r_mem0 is always the head; a pop shifts r_mem1 forward.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mem0 <= '0;
         r_mem1 <= '0;
         r_occ  <= 2'd0;
      end else begin
         case ({i_wr, i_pop})
            2'b11: begin
               if (r_occ == 2'd1) begin
                  r_mem0 <= i_wdata;
               end else begin
                  r_mem0 <= r_mem1;
                  r_mem1 <= i_wdata;
               end
            end
            2'b01: begin
               r_mem0 <= r_mem1;
               r_occ  <= r_occ - 2'd1;
            end
            2'b10: begin
               if (r_occ == 2'd0) begin
                  r_mem0 <= i_wdata;
               end else begin
                  r_mem1 <= i_wdata;
               end
               r_occ <= r_occ + 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign o_head = r_mem0;
   assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_drain.sv
// Drains an upstream FIFO (1-cycle read latency) into a valid/ready stream.
// Define FIFO_DRAIN_BURST_EN to read only in bursts of BURST_LEN words.
module fifo_drain
   import fifo_drain_pkg::*;
#(
   parameter int DW        = DEF_DW,
   parameter int AW        = DEF_AW,
   parameter int BURST_LEN = DEF_BURST_LEN
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [AW:0]   fifo_use,
   output logic          fifo_rd,
   input  logic [DW-1:0] fifo_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [15:0]   out_cnt,
   output state_t        dbg_state
);

   // Handshake: a word transfers on a rising edge where out_valid && out_ready;
   // out_valid never waits on out_ready and out_data holds until the transfer.
   logic        r_inflight;
   logic [15:0] r_cnt;
   logic [1:0]  w_occ;
   logic [2:0]  w_level;
   logic        w_pop;
   logic        w_rd_ok;
   logic        w_rd;

   assign out_valid = (w_occ != 2'd0);
   assign w_pop     = out_valid & out_ready;
   // Words owned after this edge if no read is issued; a read needs a free slot.
   assign w_level   = 3'(w_occ) + 3'(r_inflight) - 3'(w_pop);
   assign w_rd_ok   = rst_n & en & (fifo_use != '0) & (w_level < 3'd2);

`ifdef FIFO_DRAIN_BURST_EN
   localparam int          CW        = $clog2(BURST_LEN + 1);
   localparam logic [AW:0] BURST_USE = (AW+1)'(BURST_LEN);

   state_t          r_state;
   logic [CW-1:0]   r_burst;

   assign w_rd = w_rd_ok & (r_state == BURST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_burst <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (en && (fifo_use >= BURST_USE)) begin
                  r_state <= BURST;
                  r_burst <= CW'(BURST_LEN);
               end
            end
            BURST: begin
               if (w_rd) begin
                  r_burst <= r_burst - CW'(1);
                  if (r_burst == CW'(1)) begin
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign dbg_state = r_state;
`else
   assign w_rd      = w_rd_ok;
   assign dbg_state = IDLE;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_inflight <= 1'b0;
         r_cnt      <= 16'd0;
      end else begin
         r_inflight <= w_rd;
         r_cnt      <= r_cnt + 16'(w_pop);
      end
   end

   fifo_drain_skid #(
      .DW (DW)
   ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_wr    (r_inflight),
      .i_wdata (fifo_data),
      .i_pop   (w_pop),
      .o_head  (out_data),
      .o_occ   (w_occ)
   );

   assign fifo_rd = w_rd;
   assign out_cnt = r_cnt;

endmodule

// File: tb/tb_fifo_drain.sv
// Self-checking bench for fifo_drain: upstream FIFO model, scoreboard, vector table.
module tb_fifo_drain;
   import fifo_drain_pkg::*;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int BL = 4;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          en        = 1'b0;
   logic          out_ready = 1'b0;
   logic [AW:0]   fifo_use  = '0;
   logic [DW-1:0] fifo_data = '0;
   logic          fifo_rd;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [15:0]   out_cnt;
   state_t        dbg_state;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] up_q[$];
   logic [DW-1:0] exp_q[$];

   int            n_rd = 0;
   int            n_pop = 0;
   logic          m_pop;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;

   typedef struct packed {
      logic        en;
      logic        rdy;
      logic        rd;
      logic        vld;
      logic [7:0]  data;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs[11];

   always #5 clk = ~clk;

   fifo_drain #(
      .DW        (DW),
      .AW        (AW),
      .BURST_LEN (BL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .fifo_use  (fifo_use),
      .fifo_rd   (fifo_rd),
      .fifo_data (fifo_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_cnt   (out_cnt),
      .dbg_state (dbg_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Upstream FIFO: data one cycle after the strobe, occupancy saturates at depth 16.
   always @(posedge clk) begin
      if (fifo_rd) begin
         if (up_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL upstream_underflow: read strobe with empty FIFO at %0t", $time);
         end else begin
            fifo_data <= up_q.pop_front();
         end
      end
      fifo_use <= (up_q.size() > 16) ? (AW+1)'(16) : (AW+1)'(up_q.size());
   end

   // Scoreboard and protocol monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         n_rd       = 0;
         n_pop      = 0;
         prev_stall = 1'b0;
      end else begin
         m_pop = out_valid && out_ready;
         if (fifo_rd) begin
            check("rd_capacity", 32'((n_rd - n_pop - int'(m_pop)) < 2), 32'd1);
         end
         if (prev_stall && out_valid) begin
            check("stall_hold", 32'(out_data), 32'(prev_data));
         end
         if (m_pop) begin
            if (exp_q.size() == 0) begin
               check("pop_unexpected", 32'd1, 32'd0);
            end else begin
               check("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
         end
         n_rd       = n_rd + int'(fifo_rd);
         n_pop      = n_pop + int'(m_pop);
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d);
      up_q.push_back(d);
      exp_q.push_back(d);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      en        = 1'b0;
      out_ready = 1'b0;
      up_q.delete();
      exp_q.delete();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(input string name, input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int r0;
      //                 en    rdy   rd    vld   data   cnt
      vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0};
      vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 16'd0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 16'd0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 16'd0};
      vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h20, 16'd0};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h21, 16'd1};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 16'd2};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 16'd2};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'd3};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h23, 16'd3};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'd4};

      do_reset();
      @(negedge clk);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_cnt", 32'(out_cnt), 32'd0);
      check("rst_rd", 32'(fifo_rd), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      tick();

      // Empty upstream: nothing may be read or presented.
      en        = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("empty_rd_valid", 32'({fifo_rd, out_valid}), 32'd0);
         tick();
      end
      en = 1'b0;

`ifndef FIFO_DRAIN_BURST_EN
      // Cycle-exact table: startup, stalls, en drop, upstream running dry.
      do_reset();
      for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
      tick();
      for (int i = 0; i < 11; i++) begin
         en        = vecs[i].en;
         out_ready = vecs[i].rdy;
         @(negedge clk);
         check($sformatf("vec%0d_rd", i), 32'(fifo_rd), 32'(vecs[i].rd));
         check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].vld));
         if (vecs[i].vld) check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].data));
         check($sformatf("vec%0d_cnt", i), 32'(out_cnt), 32'(vecs[i].cnt));
         tick();
      end
      en = 1'b0;

      // Streaming at full rate: 0x10..0x17 on consecutive cycles.
      do_reset();
      for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
      tick();
      en        = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i < 8) check("stream_rd", 32'(fifo_rd), 32'd1);
         if (i >= 2) begin
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_data", 32'(out_data), 32'(8'h10 + 8'(i - 2)));
         end
         tick();
      end
      @(negedge clk);
      check("stream_cnt", 32'(out_cnt), 32'd8);
      check("stream_idle", 32'(out_valid), 32'd0);
      tick();

      // Backpressure: out_ready alternating, six words.
      do_reset();
      for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
      tick();
      en = 1'b1;
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
         out_ready = (i % 2 == 0);
         tick();
      end
      check("bp_drain", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      check("bp_cnt", 32'(out_cnt), 32'd6);
      tick();

      // Reset with one word buffered and one in flight.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
      exp_q.delete();
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      up_q.delete();
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_cnt", 32'(out_cnt), 32'd0);
      check("mid_rst_rd", 32'(fifo_rd), 32'd0);
      tick();
      @(negedge clk);
      check("mid_rst_discard", 32'(out_valid), 32'd0);
      tick();

      // Counter wrap after 65537 deliveries.
      do_reset();
      for (int i = 0; i < 65537; i++) push(DW'(i));
      en        = 1'b1;
      out_ready = 1'b1;
      wait_drain("wrap_drain", 66000);
      @(negedge clk);
      check("wrap_cnt", 32'(out_cnt), 32'd1);
      tick();
`else
      // Below threshold: no burst starts.
      do_reset();
      for (int i = 0; i < 3; i++) push(8'h50 + 8'(i));
      tick();
      en        = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("burst_idle_rd", 32'(fifo_rd), 32'd0);
         tick();
      end
      check("burst_idle_state", 32'(dbg_state), 32'(IDLE));

      // Threshold reached: exactly BURST_LEN reads, then back to IDLE.
      r0 = n_rd;
      push(8'h53);
      push(8'h54);
      for (int i = 0; i < 15; i++) tick();
      check("burst_reads", 32'(n_rd - r0), 32'(BL));
      check("burst_end_state", 32'(dbg_state), 32'(IDLE));
      check("burst_left", 32'(exp_q.size()), 32'd1);
      check("burst_cnt", 32'(out_cnt), 32'd4);

      // en dropped mid-burst: reads pause, state holds, burst completes later.
      r0 = n_rd;
      for (int i = 0; i < 3; i++) push(8'h55 + 8'(i));
      for (int i = 0; i < 20 && (n_rd - r0) < 2; i++) tick();
      check("pause_reach", 32'(n_rd - r0), 32'd2);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("pause_rd", 32'(fifo_rd), 32'd0);
         check("pause_state", 32'(dbg_state), 32'(BURST));
         tick();
      end
      en = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("resume_reads", 32'(n_rd - r0), 32'(BL));
      check("resume_state", 32'(dbg_state), 32'(IDLE));
      wait_drain("resume_drain", 20);
      @(negedge clk);
      check("resume_cnt", 32'(out_cnt), 32'd8);
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
